// File: rtl/alu4bit_core.sv
// 4-bit, 8-function ALU slice with registered result and carry.
// Optional ALU_ZERO_FLAG_EN adds a registered zero flag output.
package alu4bit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_DEC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic inc;
    logic dec;
    logic land;
    logic lor;
    logic lxor;
    logic lnot;
  } op_dec_t;

  typedef struct packed {
    logic       c;
    logic [3:0] r;
  } res_t;

endpackage

module alu4bit_core
  import alu4bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       m,
  input  logic       s1,
  input  logic       s0,
  output logic       CiOut,
`ifdef ALU_ZERO_FLAG_EN
  output logic       zero,
`endif
  output logic       f3,
  output logic       f2,
  output logic       f1,
  output logic       f0
);

  op_t        op;
  op_dec_t    dec;
  logic [3:0] opb;
  logic       cin;
  logic [4:0] sum;
  logic [3:0] lres;
  res_t       res;
  res_t       q;

  assign op = op_t'({m, s1, s0});

  // One-hot decode of the 3-bit opcode
  always_comb begin
    dec = '0;
    unique case (op)
      OP_ADD:  dec.add  = 1'b1;
      OP_SUB:  dec.sub  = 1'b1;
      OP_INC:  dec.inc  = 1'b1;
      OP_DEC:  dec.dec  = 1'b1;
      OP_AND:  dec.land = 1'b1;
      OP_OR:   dec.lor  = 1'b1;
      OP_XOR:  dec.lxor = 1'b1;
      OP_NOT:  dec.lnot = 1'b1;
      default: dec      = '0;
    endcase
  end

  // Shared adder: pick second operand and carry-in per arithmetic op
  always_comb begin
    opb = 4'b0000;
    cin = 1'b0;
    unique case (1'b1)
      dec.add: begin
        opb = B;
        cin = 1'b0;
      end
      dec.sub: begin
        opb = ~B;
        cin = 1'b1;
      end
      dec.inc: begin
        opb = 4'b0000;
        cin = 1'b1;
      end
      dec.dec: begin
        opb = 4'b1111;
        cin = 1'b0;
      end
      default: begin
        opb = 4'b0000;
        cin = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, A} + {1'b0, opb} + {4'b0000, cin};

  // Bitwise logic unit
  always_comb begin
    lres = 4'b0000;
    unique case (1'b1)
      dec.land: lres = A & B;
      dec.lor:  lres = A | B;
      dec.lxor: lres = A ^ B;
      dec.lnot: lres = ~A;
      default:  lres = 4'b0000;
    endcase
  end

  // Mode select: logic ops never produce a carry
  always_comb begin
    res = '0;
    if (m) begin
      res.r = lres;
      res.c = 1'b0;
    end else begin
      res.r = sum[3:0];
      res.c = sum[4];
    end
  end

  // Output register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= res;
    end
  end

  assign CiOut = q.c;
  assign f3    = q.r[3];
  assign f2    = q.r[2];
  assign f1    = q.r[1];
  assign f0    = q.r[0];

`ifdef ALU_ZERO_FLAG_EN
  logic zq;

  // Zero flag register; reset result is 0000 so flag resets high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zq <= 1'b1;
    end else begin
      zq <= (res.r == 4'b0000);
    end
  end

  assign zero = zq;
`endif

endmodule

// File: tb/tb_alu4bit_core.sv
// Directed self-checking bench for alu4bit_core.
// Define ALU_ZERO_FLAG_EN to also check the zero flag.
module tb_alu4bit_core;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       m;
  logic       s1;
  logic       s0;
  logic       CiOut;
  logic       f3;
  logic       f2;
  logic       f1;
  logic       f0;
`ifdef ALU_ZERO_FLAG_EN
  logic       zero;
`endif

  int n_cmp;
  int n_bad;

  alu4bit_core dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .m     (m),
    .s1    (s1),
    .s0    (s0),
    .CiOut (CiOut),
`ifdef ALU_ZERO_FLAG_EN
    .zero  (zero),
`endif
    .f3    (f3),
    .f2    (f2),
    .f1    (f1),
    .f0    (f0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [4:0] got,
    input logic [4:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs();
    return {CiOut, f3, f2, f1, f0};
  endfunction

  task automatic drive(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    {m, s1, s0} = op;
    A = a;
    B = b;
  endtask

  // Drive at negedge, check one cycle later just after posedge
  task automatic apply(
    input string      tag,
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] ef,
    input logic       ec
  );
    @(negedge clk);
    rst = 1'b0;
    drive(op, a, b);
    @(posedge clk);
    #1;
    chk(tag, obs(), {ec, ef});
`ifdef ALU_ZERO_FLAG_EN
    chk({tag, "_z"}, {4'b0000, zero}, {4'b0000, ef == 4'b0000});
`endif
  endtask

  logic [3:0] sw1_f [8];
  logic       sw1_c [8];
  logic [3:0] sw2_f [8];
  logic       sw2_c [8];

  initial begin
    sw1_f = '{4'b1001, 4'b0001, 4'b0110, 4'b0100,
              4'b0100, 4'b0101, 4'b0001, 4'b1010};
    sw1_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sw2_f = '{4'b1111, 4'b0101, 4'b1011, 4'b1001,
              4'b0000, 4'b1111, 4'b1111, 4'b0101};
    sw2_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp = 0;
    n_bad = 0;

    rst = 1'b1;
    drive(3'b000, 4'b1111, 4'b0001);
    #1;
    chk("rst_now", obs(), 5'b00000);
`ifdef ALU_ZERO_FLAG_EN
    chk("rst_now_z", {4'b0000, zero}, 5'b00001);
`endif
    @(posedge clk);
    #1;
    chk("rst_hold", obs(), 5'b00000);

    apply("rst_rel_add", 3'b000, 4'b0101, 4'b0100, 4'b1001, 1'b0);

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("sw1_op%0d", i), 3'(i), 4'b0101, 4'b0100,
            sw1_f[i], sw1_c[i]);
    end
    for (int i = 0; i < 8; i++) begin
      apply($sformatf("sw2_op%0d", i), 3'(i), 4'b1010, 4'b0101,
            sw2_f[i], sw2_c[i]);
    end

    apply("add_wrap", 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1);
    apply("inc_wrap", 3'b010, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    apply("dec_wrap", 3'b011, 4'b0000, 4'b1010, 4'b1111, 1'b0);
    apply("sub_eq", 3'b001, 4'b0011, 4'b0011, 4'b0000, 1'b1);
    apply("sub_brw", 3'b001, 4'b0000, 4'b0001, 4'b1111, 1'b0);
    apply("and_zero", 3'b100, 4'b1010, 4'b0101, 4'b0000, 1'b0);
    apply("or_nz", 3'b101, 4'b1010, 4'b0101, 4'b1111, 1'b0);

    apply("lat_pre", 3'b000, 4'b0001, 4'b0001, 4'b0010, 1'b0);
    #2;
    drive(3'b110, 4'b0001, 4'b0001);
    #1;
    chk("lat_hold", obs(), 5'b00010);
    @(posedge clk);
    #1;
    chk("lat_next", obs(), 5'b00000);

    apply("ar_pre", 3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0);
    drive(3'b000, 4'b1111, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_clear", obs(), 5'b00000);
`ifdef ALU_ZERO_FLAG_EN
    chk("ar_clear_z", {4'b0000, zero}, 5'b00001);
`endif
    @(posedge clk);
    #1;
    chk("ar_hold", obs(), 5'b00000);
    apply("ar_rel_inc", 3'b010, 4'b0100, 4'b0000, 4'b0101, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu4bit_core.md
Name: alu4bit_core

Overview:
- 4-bit, 8-function ALU with registered outputs.
- Mode bit m selects arithmetic (m=0) or bitwise logic (m=1); s1/s0 select one of four operations within the mode.
- Result is presented on four discrete bit outputs f3..f0 plus a carry output CiOut.
- Used as the datapath slice of the lab ALU; 8-bit configurations cascade two slices externally.

Parameters:
- none (width fixed at 4)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  4  operand A
- B  input  4  operand B
- m  input  1  mode: 0 = arithmetic, 1 = logic
- s1  input  1  operation select, MSB
- s0  input  1  operation select, LSB
- CiOut  output  1  registered carry out (arithmetic ops); 0 for logic ops
- f3  output  1  registered result bit 3 (MSB)
- f2  output  1  registered result bit 2
- f1  output  1  registered result bit 1
- f0  output  1  registered result bit 0 (LSB)

Behaviour:
- Opcode is {m,s1,s0}. The combinational result R[3:0] and carry C are defined per opcode:
  - 000 ADD: {C,R} = A + B
  - 001 SUB: {C,R} = A + ~B + 1. C=1 means no borrow (A >= B unsigned).
  - 010 INC: {C,R} = A + 1
  - 011 DEC: {C,R} = A + 4'b1111. C=0 only when A == 0.
  - 100 AND: R = A & B, C = 0
  - 101 OR: R = A | B, C = 0
  - 110 XOR: R = A ^ B, C = 0
  - 111 NOT: R = ~A, C = 0
- All arithmetic is unsigned, modulo 16. Carry is the 5th bit of the 5-bit sum.
- Registers: on each rising clk edge, {f3,f2,f1,f0} <= R and CiOut <= C.
- Latency is exactly 1 cycle from inputs to outputs. There is no enable; the registers update every cycle.
- Inputs may change every cycle. Each cycle's output reflects only the inputs sampled at the preceding edge; no state carries between operations.
- Reset: while rst=1, f3..f0 = 0 and CiOut = 0 immediately, independent of clk.
- Reset deassertion: the first rising edge with rst=0 loads the current inputs.
- Reset asserted mid-stream clears the outputs at once; any in-flight result is discarded.
- Wrap-around:
  - ADD 1111+0001 -> 0000, CiOut=1
  - INC 1111 -> 0000, CiOut=1
  - DEC 0000 -> 1111, CiOut=0
  - SUB 0000-0001 -> 1111, CiOut=0
- No X propagation from unused paths; every opcode drives defined values.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- When defined: add output port zero (1 bit), registered with the other outputs. zero = 1 when R == 0000 for any opcode. Reset value of zero is 1, since the reset result is 0000.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 with arbitrary inputs -> f=0000, CiOut=0. Release rst, A=0101, B=0100, op 000 -> next edge f=1001, CiOut=0.
- A=0101, B=0100, sweep ops 000..111 one per cycle -> f = 1001, 0001, 0110, 0100, 0100, 0101, 0001, 1010. CiOut = 0, 1, 0, 1, 0, 0, 0, 0.
- A=1010, B=0101, sweep ops 000..111 -> f = 1111, 0101, 1011, 1001, 0000, 1111, 1111, 0101. CiOut = 0, 1, 0, 1, 0, 0, 0, 0.
- Boundaries:
  - ADD 1111+0001 -> 0000, CiOut=1
  - INC A=1111 -> 0000, CiOut=1
  - DEC A=0000 -> 1111, CiOut=0
  - SUB 0011-0011 -> 0000, CiOut=1
- Latency and async reset: change the op mid-cycle and check the outputs change only at the next rising edge. Assert rst between edges and check the outputs clear without waiting for a clock.
- With ALU_ZERO_FLAG_EN:
  - AND 1010&0101 -> zero=1
  - OR of the same operands -> zero=0
  - zero=1 during reset
